// File: rtl/color_blob_tracker_pkg.sv
// Shared types and constants for the colour blob tracker: frame geometry defaults,
// RGB565 field positions, accumulator widths, FSM states and the pixel window test.
package color_blob_tracker_pkg;

    localparam int H_RES_DEF = 320;
    localparam int V_RES_DEF = 240;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    localparam int SUM_W = 25;
    localparam int CNT_W = 17;
    localparam int XW    = 9;
    localparam int YW    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DIV_X,
        ST_DIV_Y,
        ST_PUBLISH
    } state_t;

    typedef struct packed {
        logic [4:0] r_lo;
        logic [4:0] r_hi;
        logic [5:0] g_lo;
        logic [5:0] g_hi;
        logic [4:0] b_lo;
        logic [4:0] b_hi;
    } thresh_t;

    // Inclusive unsigned windows; an inverted window (lo > hi) can never match.
    function automatic logic pix_match(input logic [15:0] pix, input thresh_t t);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = pix[R_MSB:R_LSB];
        g = pix[G_MSB:G_LSB];
        b = pix[B_MSB:B_LSB];
        return (r >= t.r_lo) && (r <= t.r_hi) &&
               (g >= t.g_lo) && (g <= t.g_hi) &&
               (b >= t.b_lo) && (b <= t.b_hi);
    endfunction

endpackage

// File: rtl/color_blob_tracker_if.sv
// Frame-buffer read port: the tracker drives address/strobe, the buffer returns data.
interface color_blob_tracker_if #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [31:0]       rd_data;

    modport master (output rd_addr, output rd_en, input rd_data);
    modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/color_blob_tracker_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses with the quotient valid.
module color_blob_tracker_seq_divider #(
    parameter int N_W = 25,
    parameter int D_W = 17
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           done,
    output logic [N_W-1:0] quotient
);
    localparam int CW = $clog2(N_W + 1);

    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    logic [N_W-1:0] quo_q;
    logic [D_W-1:0] rem_q;
    logic [D_W-1:0] dsr_q;
    logic [D_W:0]   trial;
    logic [D_W:0]   diff;

    // Shift the next dividend bit into the remainder and try to subtract.
    assign trial = {rem_q, quo_q[N_W-1]};
    assign diff  = trial - {1'b0, dsr_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
            cnt_q  <= CW'(N_W);
        end else if (busy_q) begin
            cnt_q  <= cnt_q - 1'b1;
            busy_q <= (cnt_q != CW'(1));
            done_q <= (cnt_q == CW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
        end else if (busy_q) begin
            if (!diff[D_W]) begin
                rem_q <= diff[D_W-1:0];
                quo_q <= {quo_q[N_W-2:0], 1'b1};
            end else begin
                rem_q <= trial[D_W-1:0];
                quo_q <= {quo_q[N_W-2:0], 1'b0};
            end
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/color_blob_tracker.sv
// Scans a completed frame, classifies each pixel against colour windows and publishes
// bounding box, pixel count and centroid of the matching pixels once per frame.
module color_blob_tracker
    import color_blob_tracker_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4:0]           r_lo,
    input  logic [4:0]           r_hi,
    input  logic [5:0]           g_lo,
    input  logic [5:0]           g_hi,
    input  logic [4:0]           b_lo,
    input  logic [4:0]           b_hi,
    color_blob_tracker_if.master fb,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [CNT_W-1:0]     pix_count,
    output logic [XW-1:0]        x_min,
    output logic [XW-1:0]        x_max,
    output logic [YW-1:0]        y_min,
    output logic [YW-1:0]        y_max,
    output logic [XW-1:0]        cx,
    output logic [YW-1:0]        cy
);
    state_t            state_q, state_d;
    thresh_t           thr_q;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [1:0]        drain_q, drain_d;
    logic              div_run_q, div_run_d;
    logic [XW-1:0]     qx_q, qx_d;
    logic              issue, acc_clr, div_start, pub_load;

    logic [SUM_W-1:0]  sum_x_q, sum_y_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XW-1:0]     xmin_q, xmax_q;
    logic [YW-1:0]     ymin_q, ymax_q;

    logic [RD_LAT-1:0] vld_p;
    logic [XW-1:0]     x_p [RD_LAT];
    logic [YW-1:0]     y_p [RD_LAT];

    logic              div_done;
    logic [SUM_W-1:0]  div_quo;
    logic [SUM_W-1:0]  div_num;
    logic              hit;
    logic [XW-1:0]     hx;
    logic [YW-1:0]     hy;
    logic [ADDR_W-1:0] pix_idx;
    logic              unused_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            drain_q   <= '0;
            div_run_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            drain_q   <= drain_d;
            div_run_q <= div_run_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        drain_d   = drain_q;
        div_run_d = div_run_q;
        qx_d      = qx_q;
        issue     = 1'b0;
        acc_clr   = 1'b0;
        div_start = 1'b0;
        pub_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_clr = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                issue = 1'b1;
                if (x_q == XW'(H_RES - 1)) begin
                    x_d = '0;
                    if (y_q == YW'(V_RES - 1)) begin
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 2'(RD_LAT - 1)) begin
                    state_d = ST_DIV_X;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_DIV_X: begin
                // An empty frame skips both divides and publishes zeros.
                if (cnt_q == '0) begin
                    pub_load = 1'b1;
                    state_d  = ST_PUBLISH;
                end else if (!div_run_q) begin
                    div_start = 1'b1;
                    div_run_d = 1'b1;
                end else if (div_done) begin
                    qx_d      = div_quo[XW-1:0];
                    div_run_d = 1'b0;
                    state_d   = ST_DIV_Y;
                end
            end
            ST_DIV_Y: begin
                if (!div_run_q) begin
                    div_start = 1'b1;
                    div_run_d = 1'b1;
                end else if (div_done) begin
                    pub_load  = 1'b1;
                    div_run_d = 1'b0;
                    state_d   = ST_PUBLISH;
                end
            end
            ST_PUBLISH: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && start) begin
            thr_q <= {r_lo, r_hi, g_lo, g_hi, b_lo, b_hi};
        end
        qx_q <= qx_d;
    end

    // ---- read issue: address and strobe follow the scan counters
    assign pix_idx     = ADDR_W'(y_q) * ADDR_W'(H_RES) + ADDR_W'(x_q);
    assign fb.rd_en    = issue;
    assign fb.rd_addr  = issue ? {pix_idx[ADDR_W-3:0], 2'b00} : '0;

    // ---- coordinate pipeline aligned to rd_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        x_p[0] <= x_q;
        y_p[0] <= y_q;
        for (int i = 1; i < RD_LAT; i++) begin
            x_p[i] <= x_p[i-1];
            y_p[i] <= y_p[i-1];
        end
    end

    // ---- match and accumulate on the returned pixel
    assign hit = vld_p[RD_LAT-1] && pix_match(fb.rd_data[15:0], thr_q);
    assign hx  = x_p[RD_LAT-1];
    assign hy  = y_p[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
            cnt_q   <= '0;
            xmin_q  <= '1;
            ymin_q  <= '1;
            xmax_q  <= '0;
            ymax_q  <= '0;
        end else if (acc_clr) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
            cnt_q   <= '0;
            xmin_q  <= '1;
            ymin_q  <= '1;
            xmax_q  <= '0;
            ymax_q  <= '0;
        end else if (hit) begin
            sum_x_q <= sum_x_q + SUM_W'(hx);
            sum_y_q <= sum_y_q + SUM_W'(hy);
            cnt_q   <= cnt_q + 1'b1;
            if (hx < xmin_q) xmin_q <= hx;
            if (hx > xmax_q) xmax_q <= hx;
            if (hy < ymin_q) ymin_q <= hy;
            if (hy > ymax_q) ymax_q <= hy;
        end
    end

    // ---- shared divider: x centroid first, then y
    assign div_num = (state_q == ST_DIV_Y) ? sum_y_q : sum_x_q;

    color_blob_tracker_seq_divider #(
        .N_W (SUM_W),
        .D_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_num),
        .divisor  (cnt_q),
        .done     (div_done),
        .quotient (div_quo)
    );

    // ---- published results, loaded as the FSM enters PUBLISH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found     <= 1'b0;
            pix_count <= '0;
            x_min     <= '0;
            x_max     <= '0;
            y_min     <= '0;
            y_max     <= '0;
            cx        <= '0;
            cy        <= '0;
        end else if (pub_load) begin
            found     <= (cnt_q != '0);
            pix_count <= cnt_q;
            x_min     <= (cnt_q != '0) ? xmin_q : '0;
            x_max     <= xmax_q;
            y_min     <= (cnt_q != '0) ? ymin_q : '0;
            y_max     <= ymax_q;
            cx        <= (cnt_q != '0) ? qx_q : '0;
            cy        <= (cnt_q != '0) ? div_quo[YW-1:0] : '0;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_PUBLISH);

    assign unused_bits = ^{fb.rd_data[31:16], div_quo[SUM_W-1:XW]};

endmodule
